// File: rtl/mac_lookup_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lookup_arbiter_if
//  Description : Requester-side bundle of the MAC lookup arbiter: per-requester
//                request handshake with packed fields and shared responses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mac_lookup_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int PORT_BITS = 6
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*12-1:0]        req_src_vlan;
    logic [NUM_REQ*48-1:0]        req_src_mac;
    logic [NUM_REQ*PORT_BITS-1:0] req_src_port;
    logic [NUM_REQ*48-1:0]        req_dst_mac;
    logic [NUM_REQ-1:0]           resp_valid;
    logic                         resp_hit;
    logic [PORT_BITS-1:0]         resp_dst_port;

    modport master (
        output req_valid, req_src_vlan, req_src_mac, req_src_port, req_dst_mac,
        input  req_ready, resp_valid, resp_hit, resp_dst_port
    );

    modport slave (
        input  req_valid, req_src_vlan, req_src_mac, req_src_port, req_dst_mac,
        output req_ready, resp_valid, resp_hit, resp_dst_port
    );
endinterface
`default_nettype wire

// File: rtl/mac_lookup_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mac_lookup_arbiter
//  Description : Round-robin arbiter sharing one MAC table lookup port between
//                NUM_REQ requesters; an ID FIFO routes in-order completions
//                back to their issuers.
//                Optional per-requester statistics: MAC_LOOKUP_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_lookup_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int PORT_BITS       = 6
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    mac_lookup_arbiter_if.slave               req_if,
    output logic                              lookup_en_o,
    output logic [11:0]                       lookup_src_vlan_o,
    output logic [47:0]                       lookup_src_mac_o,
    output logic [PORT_BITS-1:0]              lookup_src_port_o,
    output logic [47:0]                       lookup_dst_mac_o,
    input  wire logic                         lookup_done_i,
    input  wire logic                         lookup_hit_i,
    input  wire logic [PORT_BITS-1:0]         lookup_dst_port_i,
    output logic                              err_spurious_o
`ifdef MAC_LOOKUP_ARB_STATS_EN
    ,
    input  wire logic [$clog2(NUM_REQ)-1:0]   stats_sel_i,
    output logic [31:0]                       stats_grants_o,
    output logic [31:0]                       stats_stalls_o
`endif
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [c_IDX_W-1:0]   rr_ptr_q;
    logic [c_IDX_W-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [c_PTR_W-1:0]   wr_ptr_q;
    logic [c_PTR_W-1:0]   rd_ptr_q;
    logic [c_CNT_W-1:0]   count_q;
    logic [c_CNT_W-1:0]   count_d;

    logic                 lookup_en_q;
    logic [11:0]          lookup_src_vlan_q;
    logic [47:0]          lookup_src_mac_q;
    logic [PORT_BITS-1:0] lookup_src_port_q;
    logic [47:0]          lookup_dst_mac_q;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic                 resp_hit_q;
    logic [PORT_BITS-1:0] resp_dst_port_q;
    logic                 err_spurious_q;

    logic                 w_pop;
    logic                 w_push;
    logic                 w_spurious;
    logic                 w_can_grant;
    logic                 w_gnt_vld;
    logic [c_IDX_W-1:0]   w_gnt_idx;
    logic [c_IDX_W:0]     w_cand;
    logic [NUM_REQ-1:0]   w_gnt_onehot;
    logic [c_IDX_W-1:0]   w_head;
    logic [11:0]          w_sel_vlan;
    logic [47:0]          w_sel_smac;
    logic [PORT_BITS-1:0] w_sel_sport;
    logic [47:0]          w_sel_dmac;

    // A push is only visible next cycle, so done with an empty FIFO is spurious
    // even when a grant lands in the same cycle.
    assign w_pop       = lookup_done_i && (count_q != '0);
    assign w_spurious  = lookup_done_i && (count_q == '0);
    assign w_can_grant = (count_q < c_CNT_W'(MAX_OUTSTANDING)) || w_pop;
    assign w_push      = w_gnt_vld;
    assign w_head      = fifo_q[rd_ptr_q];

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, rr_ptr_q} + (c_IDX_W+1)'(k);
            if (w_cand >= (c_IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (c_IDX_W+1)'(NUM_REQ);
            end
            if (!w_gnt_vld && w_can_grant && req_if.req_valid[w_cand[c_IDX_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand[c_IDX_W-1:0];
            end
        end
    end

    assign w_gnt_onehot     = w_gnt_vld ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign req_if.req_ready = w_gnt_onehot;

    always_comb begin
        w_sel_vlan  = '0;
        w_sel_smac  = '0;
        w_sel_sport = '0;
        w_sel_dmac  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == c_IDX_W'(i)) begin
                w_sel_vlan  = req_if.req_src_vlan[i*12 +: 12];
                w_sel_smac  = req_if.req_src_mac[i*48 +: 48];
                w_sel_sport = req_if.req_src_port[i*PORT_BITS +: PORT_BITS];
                w_sel_dmac  = req_if.req_dst_mac[i*48 +: 48];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ID storage needs no reset: entries are only read behind a non-zero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_q[wr_ptr_q] <= w_gnt_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q          <= c_IDX_W'(NUM_REQ - 1);
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            lookup_en_q       <= 1'b0;
            lookup_src_vlan_q <= '0;
            lookup_src_mac_q  <= '0;
            lookup_src_port_q <= '0;
            lookup_dst_mac_q  <= '0;
            resp_valid_q      <= '0;
            resp_hit_q        <= 1'b0;
            resp_dst_port_q   <= '0;
            err_spurious_q    <= 1'b0;
        end else begin
            lookup_en_q <= w_push;
            count_q     <= count_d;
            if (w_push) begin
                rr_ptr_q          <= w_gnt_idx;
                wr_ptr_q          <= wr_ptr_q + c_PTR_W'(1);
                lookup_src_vlan_q <= w_sel_vlan;
                lookup_src_mac_q  <= w_sel_smac;
                lookup_src_port_q <= w_sel_sport;
                lookup_dst_mac_q  <= w_sel_dmac;
            end
            if (w_pop) begin
                rd_ptr_q        <= rd_ptr_q + c_PTR_W'(1);
                resp_valid_q    <= NUM_REQ'(1) << w_head;
                resp_hit_q      <= lookup_hit_i;
                resp_dst_port_q <= lookup_dst_port_i;
            end else begin
                resp_valid_q    <= '0;
            end
            if (w_spurious) begin
                err_spurious_q <= 1'b1;
            end
        end
    end

    assign lookup_en_o          = lookup_en_q;
    assign lookup_src_vlan_o    = lookup_src_vlan_q;
    assign lookup_src_mac_o     = lookup_src_mac_q;
    assign lookup_src_port_o    = lookup_src_port_q;
    assign lookup_dst_mac_o     = lookup_dst_mac_q;
    assign req_if.resp_valid    = resp_valid_q;
    assign req_if.resp_hit      = resp_hit_q;
    assign req_if.resp_dst_port = resp_dst_port_q;
    assign err_spurious_o       = err_spurious_q;

`ifdef MAC_LOOKUP_ARB_STATS_EN
    logic [31:0] grants_q [NUM_REQ];
    logic [31:0] stalls_q [NUM_REQ];
    logic [31:0] stats_grants_q;
    logic [31:0] stats_stalls_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grants_q[i] <= '0;
                stalls_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_if.req_valid[i] && w_gnt_onehot[i] && (grants_q[i] != '1)) begin
                    grants_q[i] <= grants_q[i] + 32'd1;
                end
                if (req_if.req_valid[i] && !w_gnt_onehot[i] && (stalls_q[i] != '1)) begin
                    stalls_q[i] <= stalls_q[i] + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stats_grants_q <= '0;
            stats_stalls_q <= '0;
        end else if (int'(stats_sel_i) < NUM_REQ) begin
            stats_grants_q <= grants_q[stats_sel_i];
            stats_stalls_q <= stalls_q[stats_sel_i];
        end else begin
            stats_grants_q <= '0;
            stats_stalls_q <= '0;
        end
    end

    assign stats_grants_o = stats_grants_q;
    assign stats_stalls_o = stats_stalls_q;
`endif

endmodule
`default_nettype wire

// File: doc/mac_lookup_arbiter.md
Name: mac_lookup_arbiter

Overview:
- Shares the single lookup port of the MAC address table between NUM_REQ requesters, typically one input-buffering block per line card.
- Grants requests round-robin and forwards each granted request to the table as a one-cycle lookup strobe.
- Tracks issue order of outstanding lookups in an ID FIFO, and steers each table completion (hit, dst_port) back to the requester that issued it.
- Sits between the line-card input buffering blocks and the MAC address table, in the fabric clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 8, max lookups in flight in the table; ID FIFO depth (power of 2).
- PORT_BITS, 6, width of global src/dst port fields.

Ports:
- clk  in  1  fabric clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester lookup request.
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid&ready.
- req_src_vlan  in  NUM_REQ*12  packed, requester i at [i*12 +: 12].
- req_src_mac  in  NUM_REQ*48  packed source MAC.
- req_src_port  in  NUM_REQ*PORT_BITS  packed global ingress port.
- req_dst_mac  in  NUM_REQ*48  packed destination MAC.
- resp_valid  out  NUM_REQ  one-cycle completion pulse to requester i.
- resp_hit  out  1  hit flag; shared, qualified by resp_valid.
- resp_dst_port  out  PORT_BITS  destination port; shared, qualified by resp_valid.
- lookup_en  out  1  one-cycle strobe to the table.
- lookup_src_vlan  out  12  registered request field to the table.
- lookup_src_mac  out  48  registered request field to the table.
- lookup_src_port  out  PORT_BITS  registered request field to the table.
- lookup_dst_mac  out  48  registered request field to the table.
- lookup_done  in  1  table completion strobe; completions return in issue order.
- lookup_hit  in  1  table hit flag, valid with lookup_done.
- lookup_dst_port  in  PORT_BITS  table result, valid with lookup_done.
- err_spurious  out  1  sticky: lookup_done seen with the ID FIFO empty.

Behaviour:
Reset (asynchronous, active-high):
- Every registered output goes to 0: lookup_en, lookup_* fields, resp_valid, resp_hit, resp_dst_port, err_spurious.
- ID FIFO empties, outstanding count = 0.
- rr_ptr = NUM_REQ-1, so requester 0 has first priority.

Arbitration (combinational, every cycle):
- If count < MAX_OUTSTANDING, or a pop happens this same cycle, grant the first valid requester searching rr_ptr+1, rr_ptr+2, ... with modulo-NUM_REQ wrap.
- At most one req_ready bit is high per cycle, and only for a requester whose req_valid is high.
- req_ready depends combinationally on req_valid.
- Requesters hold req_valid and all fields stable until granted.

On a grant to requester g in cycle N:
- rr_ptr <= g.
- Push g into the ID FIFO.
- In cycle N+1: lookup_en=1 for exactly one cycle, lookup_* fields = requester g's fields as sampled in cycle N.
- Fields hold their last value when lookup_en=0.
- Max throughput: one lookup per cycle, provided the FIFO is not full.

Full condition:
- count == MAX_OUTSTANDING with no pop this cycle: all req_ready=0, no issue.
- Full with a simultaneous lookup_done: the pop frees a slot, so a grant is allowed in the same cycle; count stays unchanged.

Completion (lookup_done in cycle M):
- Pop the FIFO head h.
- In cycle M+1: resp_valid[h]=1 for one cycle, resp_hit=lookup_hit, resp_dst_port=lookup_dst_port.
- resp_hit and resp_dst_port hold their value otherwise.

Simultaneous push and pop:
- Both take effect; count unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING.

Spurious completion:
- lookup_done with the FIFO empty and no push this cycle: no resp_valid pulse, err_spurious <= 1, cleared only by rst.
- lookup_done with the FIFO empty but a push in the same cycle is also spurious: a push only becomes visible next cycle.

Reset mid-operation:
- In-flight lookups are discarded.
- The system resets the table on the same rst.

No starvation:
- Any requester that holds valid is granted within NUM_REQ grants.

Optional Feature:
Macro MAC_LOOKUP_ARB_STATS_EN.
- Defined: adds the following ports:
  - stats_sel  in  $clog2(NUM_REQ)
  - stats_grants  out  32
  - stats_stalls  out  32
- Per-requester counters, all reset to 0:
  - grants: increments on each valid&ready.
  - stalls: increments on each cycle with valid & !ready.
- Counters saturate at 32'hFFFFFFFF.
- stats_grants and stats_stalls are registered reads of the requester selected by stats_sel, 1-cycle latency.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Single request: req_valid[2]=1 with vlan 69, src_mac 02:00:00:00:00:01, dst_mac ff:ff:ff:ff:ff:ff → req_ready[2] in the same cycle; lookup_en one cycle later carrying exactly those fields; table done with hit=1, port 5 → resp_valid[2] one cycle after done with resp_dst_port=5.
2. All 4 requesters held valid continuously from reset, with the table completing immediately → grant order 0,1,2,3,0,1,... with one lookup_en per cycle and each response returned to its issuer.
3. Table stalled (no done): after 8 grants all req_ready=0; one lookup_done → that same cycle exactly one new grant; count stays at 8.
4. Requester 3 alone valid while rr_ptr=1 → granted immediately; then requesters 0 and 3 both valid → 0 is granted before 3 is regranted.
5. lookup_done pulsed with the FIFO empty → no resp_valid pulse and err_spurious=1; rst during 5 outstanding lookups → count=0, all outputs 0, err_spurious=0.
6. With MAC_LOOKUP_ARB_STATS_EN defined: requester 1 sees 3 grants and 4 stall cycles → stats_sel=1 reads grants=3, stalls=4 one cycle later.
